const_addr_map: RTL and testbench
=================================

Name: const_addr_map

Overview:
- Per-port coordinate-to-linear-address mapper for the CNN feature-map buffers.
- Takes PORT_NUM packed (x, y) coordinate pairs and produces PORT_NUM packed linear offsets: offset = BASE_ADDR + y*ROW_STRIDE + x.
- Sits between the coordinate generators and the bus pack/unpack helpers (26-lane bus and de-bus) feeding the feature-map RAMs.
- All ports are processed in parallel with a registered output.

Parameters:
- PORT_NUM, 4, number of parallel coordinate/offset lanes (1..26).
- DATA_W, 32, width of each x, y and offset lane in bits.
- ROW_STRIDE, 28, row pitch in address units; constant multiplier applied to y.
- BASE_ADDR, 0, constant added to every offset.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  reset, asynchronous, active-high.
- in_valid  input  1  x/y buses carry valid coordinates this cycle.
- x  input  PORT_NUM*DATA_W  packed x coordinates; lane k at bits [k*DATA_W+DATA_W-1 : k*DATA_W].
- y  input  PORT_NUM*DATA_W  packed y coordinates, same lane packing as x.
- offset  output  PORT_NUM*DATA_W  packed linear offsets, same lane packing.
- out_valid  output  1  offset holds the result for the coordinates sampled one cycle earlier.

Behaviour:
- Lane k is unsigned: offset[k] = (BASE_ADDR + y[k]*ROW_STRIDE + x[k]) mod 2^DATA_W.
  - Intermediates are computed at full width, then truncated to DATA_W bits (wrap-around, no saturation, no overflow flag).
- Lanes are fully independent; no cross-lane interaction.
- Latency: 1 clock.
  - offset and out_valid are registered.
  - On the rising edge where in_valid=1, offset loads the mapped values and out_valid goes to 1 on the next cycle.
- When in_valid=0 at a rising edge:
  - out_valid goes to 0;
  - offset holds its previous value (no load).
- Back-to-back: in_valid high for N consecutive cycles yields N consecutive out_valid cycles, each with its own result. No bubbles and no backpressure.
- Reset:
  - rst=1 asynchronously forces offset to all zeros and out_valid to 0, immediately and regardless of clk.
  - While rst=1, inputs are ignored.
  - Reset mid-stream discards the in-flight result.
  - First capture is on the first rising edge after rst deasserts.
- x or y changing while in_valid=0 has no effect on the outputs.
- No X propagation from unused upper bits: lane width is exactly PORT_NUM*DATA_W.
  - When a wider 26-lane bus drives x/y, the parent connects only the low PORT_NUM*DATA_W bits.
- Multiplication by ROW_STRIDE is by constant; the implementation may use shift-add. Results must equal the formula exactly for all inputs.

Test Plan:
- Basic map (PORT_NUM=4, ROW_STRIDE=28, BASE_ADDR=0): x={0,1,2,3}, y={29,28,27,26}, in_valid=1 for one cycle -> next cycle out_valid=1, offset lanes {812,785,758,731}; following cycle out_valid=0 and offset holds.
- Base/zero: BASE_ADDR=100, x=0, y=0 on all lanes -> all lanes 100; then x={5,0,0,0}, y={0,1,0,0} -> lanes {105,128,100,100}.
- Wrap-around: lane 0 x=0xFFFFFFFF, y=1 (ROW_STRIDE=28, BASE=0) -> lane 0 = 27. Lane 1 y=0xFFFFFFFF, x=0 -> 0xFFFFFFE4.
- Streaming: 8 consecutive valid cycles with x=i, y=29-i on all lanes (i=0..7) -> 8 consecutive out_valid cycles, cycle i offset = (29-i)*28+i; no gaps, no reordering.
- Async reset mid-stream: assert rst between clock edges while out_valid=1 -> offset=0 and out_valid=0 immediately. Deassert, then one valid input -> result appears exactly one cycle later.
- Lane independence: vary only lane 2 inputs across cycles -> lanes 0, 1, 3 unchanged.

Source files
------------

// File: rtl/const_addr_map.sv
`default_nettype none
// ============================================================================
//  Module   : const_addr_map
//  Purpose  : Per-port coordinate-to-linear-address mapper for the CNN
//             feature-map buffers. Every lane computes
//                 offset = BASE_ADDR + y * ROW_STRIDE + x   (mod 2^DATA_W)
//             All lanes run in parallel with a single registered stage.
//
//  Ports    : clk        rising-edge clock
//             rst        asynchronous active-high reset
//             in_valid   x/y carry valid coordinates this cycle
//             x, y       PORT_NUM packed DATA_W-bit coordinates
//                        (lane k at bits [k*DATA_W +: DATA_W])
//             offset     PORT_NUM packed DATA_W-bit linear offsets
//             out_valid  offset holds the result of the previous cycle's
//                        coordinates
//
//  Revision : 1.0  initial release
// ============================================================================
module const_addr_map #(
    parameter int          PORT_NUM   = 4,
    parameter int          DATA_W     = 32,
    parameter int unsigned ROW_STRIDE = 28,
    parameter int unsigned BASE_ADDR  = 0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    input  logic [PORT_NUM*DATA_W-1:0] x,
    input  logic [PORT_NUM*DATA_W-1:0] y,
    output logic [PORT_NUM*DATA_W-1:0] offset,
    output logic                       out_valid
);

    // Both constants reduced modulo 2^DATA_W. Because only the low DATA_W
    // bits of the result are kept, evaluating the whole expression in
    // DATA_W-bit modular arithmetic gives exactly the same value as a
    // full-width evaluation followed by truncation.
    localparam logic [DATA_W-1:0] c_STRIDE = DATA_W'(ROW_STRIDE);
    localparam logic [DATA_W-1:0] c_BASE   = DATA_W'(BASE_ADDR);

    logic [PORT_NUM-1:0][DATA_W-1:0] w_lanes;
    logic                            r_out_valid;

    generate
        for (genvar k = 0; k < PORT_NUM; k++) begin : g_lane
            logic [DATA_W-1:0] w_x;
            logic [DATA_W-1:0] w_y;
            logic [DATA_W-1:0] w_map;
            logic [DATA_W-1:0] r_off;

            assign w_x   = x[k*DATA_W +: DATA_W];
            assign w_y   = y[k*DATA_W +: DATA_W];
            // Constant multiplier: synthesis reduces this to shift-add.
            assign w_map = c_BASE + (w_y * c_STRIDE) + w_x;

            // Holds its last value when no new coordinates arrive.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_off <= '0;
                end else if (in_valid) begin
                    r_off <= w_map;
                end
            end

            assign w_lanes[k] = r_off;
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= in_valid;
        end
    end

    assign offset    = w_lanes;
    assign out_valid = r_out_valid;

endmodule
`default_nettype wire

// File: tb/tb_const_addr_map.sv
`default_nettype none
// ============================================================================
//  Module   : tb_const_addr_map
//  Purpose  : Self-checking bench for const_addr_map. Two instances share
//             the stimulus: BASE_ADDR=0 and BASE_ADDR=100 (both
//             PORT_NUM=4, DATA_W=32, ROW_STRIDE=28).
//  Revision : 1.0  initial release
// ============================================================================
module tb_const_addr_map;

    localparam int NP = 4;
    localparam int DW = 32;

    logic                     clk;
    logic                     rst;
    logic                     in_valid;
    logic [NP-1:0][DW-1:0]    x;
    logic [NP-1:0][DW-1:0]    y;
    logic [NP-1:0][DW-1:0]    off0;
    logic [NP-1:0][DW-1:0]    off100;
    logic                     ov0;
    logic                     ov100;

    const_addr_map #(.PORT_NUM(NP), .DATA_W(DW), .ROW_STRIDE(28), .BASE_ADDR(0)) dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .x(x), .y(y),
        .offset(off0), .out_valid(ov0)
    );

    const_addr_map #(.PORT_NUM(NP), .DATA_W(DW), .ROW_STRIDE(28), .BASE_ADDR(100)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .x(x), .y(y),
        .offset(off100), .out_valid(ov100)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state: expected register contents of both instances.
    logic [DW-1:0] m0   [NP];
    logic [DW-1:0] m100 [NP];
    logic          m_valid;

    typedef struct {
        logic [NP-1:0][DW-1:0] x;
        logic [NP-1:0][DW-1:0] y;
        logic [NP-1:0][DW-1:0] e0;
        logic [NP-1:0][DW-1:0] e100;
    } vec_t;

    vec_t vecs[4];

    // Address formula evaluated with plain 64-bit arithmetic, then reduced.
    function automatic logic [DW-1:0] map_ref(longint unsigned base,
                                              logic [DW-1:0] xv, logic [DW-1:0] yv);
        longint unsigned t;
        t = base + longint'(yv) * 64'd28 + longint'(xv);
        return t[DW-1:0];
    endfunction

    function automatic logic [NP-1:0][DW-1:0] mk(logic [DW-1:0] a0, logic [DW-1:0] a1,
                                                 logic [DW-1:0] a2, logic [DW-1:0] a3);
        logic [NP-1:0][DW-1:0] r;
        r[0] = a0; r[1] = a1; r[2] = a2; r[3] = a3;
        return r;
    endfunction

    task automatic cmp(string name, logic [DW-1:0] act, logic [DW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < NP; k++) begin
            m0[k]   = '0;
            m100[k] = '0;
        end
        m_valid = 1'b0;
    endtask

    // One clock edge; the model follows the same edge, then sample at +1.
    task automatic step();
        @(posedge clk);
        if (!rst) begin
            if (in_valid) begin
                for (int k = 0; k < NP; k++) begin
                    m0[k]   = map_ref(64'd0,   x[k], y[k]);
                    m100[k] = map_ref(64'd100, x[k], y[k]);
                end
            end
            m_valid = in_valid;
        end
        #1;
    endtask

    task automatic chk_model(string name);
        cmp({name, ".ov0"},   {31'd0, ov0},   {31'd0, m_valid});
        cmp({name, ".ov100"}, {31'd0, ov100}, {31'd0, m_valid});
        for (int k = 0; k < NP; k++) begin
            cmp($sformatf("%s.b0.lane%0d", name, k),   off0[k],   m0[k]);
            cmp($sformatf("%s.b100.lane%0d", name, k), off100[k], m100[k]);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [DW-1:0] lane2_x;
        logic [DW-1:0] lane2_y;

        vecs[0].x = mk(0, 1, 2, 3);
        vecs[0].y = mk(29, 28, 27, 26);
        vecs[0].e0   = mk(812, 785, 758, 731);
        vecs[0].e100 = mk(912, 885, 858, 831);
        vecs[1].x = mk(0, 0, 0, 0);
        vecs[1].y = mk(0, 0, 0, 0);
        vecs[1].e0   = mk(0, 0, 0, 0);
        vecs[1].e100 = mk(100, 100, 100, 100);
        vecs[2].x = mk(5, 0, 0, 0);
        vecs[2].y = mk(0, 1, 0, 0);
        vecs[2].e0   = mk(5, 28, 0, 0);
        vecs[2].e100 = mk(105, 128, 100, 100);
        vecs[3].x = mk(32'hFFFF_FFFF, 0, 0, 0);
        vecs[3].y = mk(1, 32'hFFFF_FFFF, 0, 0);
        vecs[3].e0   = mk(27, 32'hFFFF_FFE4, 0, 0);
        vecs[3].e100 = mk(127, 32'h0000_0048, 100, 100);

        // ---------------- reset state ----------------
        rst = 1'b1; in_valid = 1'b0; x = '0; y = '0;
        model_reset();
        #2;
        chk_model("reset");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // ---------------- table vectors ----------------
        for (int v = 0; v < 4; v++) begin
            x = vecs[v].x; y = vecs[v].y; in_valid = 1'b1;
            step();
            cmp($sformatf("vec%0d.ov", v), {31'd0, ov0}, 32'd1);
            for (int k = 0; k < NP; k++) begin
                cmp($sformatf("vec%0d.b0.lane%0d", v, k),   off0[k],   vecs[v].e0[k]);
                cmp($sformatf("vec%0d.b100.lane%0d", v, k), off100[k], vecs[v].e100[k]);
            end
            // Idle cycle with garbage coordinates: result must hold.
            in_valid = 1'b0;
            x = mk($urandom, $urandom, $urandom, $urandom);
            y = mk($urandom, $urandom, $urandom, $urandom);
            step();
            cmp($sformatf("vec%0d.idle_ov", v), {31'd0, ov0}, 32'd0);
            for (int k = 0; k < NP; k++)
                cmp($sformatf("vec%0d.hold.lane%0d", v, k), off0[k], vecs[v].e0[k]);
        end

        // ---------------- streaming ----------------
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1;
            for (int k = 0; k < NP; k++) begin
                x[k] = DW'(i);
                y[k] = DW'(29 - i);
            end
            step();
            cmp($sformatf("stream%0d.ov", i), {31'd0, ov0}, 32'd1);
            for (int k = 0; k < NP; k++)
                cmp($sformatf("stream%0d.lane%0d", i, k), off0[k], DW'((29 - i) * 28 + i));
        end
        in_valid = 1'b0;
        step();
        cmp("stream_end.ov", {31'd0, ov0}, 32'd0);

        // ---------------- async reset mid-stream ----------------
        x = mk(1, 2, 3, 4); y = mk(5, 6, 7, 8); in_valid = 1'b1;
        step();
        chk_model("pre_rst");
        #2;                                   // between edges
        rst = 1'b1;
        #1;
        model_reset();
        chk_model("async_rst");
        step();                               // edge under reset, inputs valid
        chk_model("held_rst");
        @(negedge clk);
        rst = 1'b0; in_valid = 1'b1;
        x = mk(10, 11, 12, 13); y = mk(2, 3, 4, 5);
        step();
        cmp("post_rst.lane0", off0[0], 32'd66);
        cmp("post_rst.lane3", off0[3], 32'd153);
        chk_model("post_rst");
        in_valid = 1'b0;
        step();
        chk_model("post_rst_idle");

        // ---------------- lane independence ----------------
        x = mk(7, 8, 0, 9); y = mk(1, 2, 0, 3);
        for (int i = 0; i < 5; i++) begin
            lane2_x = $urandom; lane2_y = $urandom;
            x[2] = lane2_x; y[2] = lane2_y; in_valid = 1'b1;
            step();
            cmp($sformatf("indep%0d.lane0", i), off0[0], 32'd35);
            cmp($sformatf("indep%0d.lane1", i), off0[1], 32'd64);
            cmp($sformatf("indep%0d.lane3", i), off0[3], 32'd93);
            cmp($sformatf("indep%0d.lane2", i), off0[2], map_ref(64'd0, lane2_x, lane2_y));
        end

        // ---------------- randomized vs reference model ----------------
        for (int i = 0; i < 300; i++) begin
            in_valid = ($urandom_range(0, 3) != 0);
            for (int k = 0; k < NP; k++) begin
                if ($urandom_range(0, 1) == 0) begin
                    x[k] = $urandom; y[k] = $urandom;
                end else begin
                    x[k] = DW'($urandom_range(0, 27)); y[k] = DW'($urandom_range(0, 27));
                end
            end
            step();
            chk_model($sformatf("rand%0d", i));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
